convolution_3x3: RTL and testbench

//  Pipelined 3x3 convolution stage. Applies the coefficient/shift/offset set from the

---
 rtl/convolution_3x3_if.sv | 33 +++
 rtl/convolution_3x3.sv | 141 ++++++++++++++
 tb/tb_convolution_3x3.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/convolution_3x3_if.sv
// Stream and kernel-load signals of the 3x3 convolution stage.
// master = upstream/downstream environment side, slave = the convolution stage.
interface convolution_3x3_if #(
   parameter int HC_W = 11,
   parameter int VC_W = 10
) ();
   logic                          kernel_load_in;
   logic signed [2:0][2:0][7:0]   coeffs_in;
   logic signed [7:0]             shift_in;
   logic signed [7:0]             offset_in;
   logic                          data_valid_in;
   logic                          in_ready_out;
   logic        [2:0][2:0][7:0]   window_in;
   logic        [HC_W-1:0]        hcount_in;
   logic        [VC_W-1:0]        vcount_in;
   logic                          data_valid_out;
   logic                          out_ready_in;
   logic        [7:0]             pixel_out;
   logic        [HC_W-1:0]        hcount_out;
   logic        [VC_W-1:0]        vcount_out;

   modport master (
      output kernel_load_in, coeffs_in, shift_in, offset_in,
      output data_valid_in, window_in, hcount_in, vcount_in, out_ready_in,
      input  in_ready_out, data_valid_out, pixel_out, hcount_out, vcount_out
   );

   modport slave (
      input  kernel_load_in, coeffs_in, shift_in, offset_in,
      input  data_valid_in, window_in, hcount_in, vcount_in, out_ready_in,
      output in_ready_out, data_valid_out, pixel_out, hcount_out, vcount_out
   );
endinterface

// File: rtl/convolution_3x3.sv
// Three-stage pipelined 3x3 convolution (multiply, sum, shift/offset/clamp).
// Define CONV_ABS_EN to take the magnitude of the shifted sum before the offset add.
module convolution_3x3 #(
   parameter int HC_W = 11,
   parameter int VC_W = 10
) (
   input logic         clk_in,
   input logic         rst_n_in,
   convolution_3x3_if.slave bus
);
   logic signed [2:0][2:0][7:0] k_coeffs;
   logic signed [7:0]           k_shift;
   logic signed [7:0]           k_offset;
   logic [3:0]                  k_sh;
   logic                        advance;

   logic [8:0][16:0]            prod_c;
   logic signed [20:0]          sum_c;
   logic signed [20:0]          shifted_c;
   logic signed [20:0]          mag_c;
   logic signed [20:0]          res_c;
   logic [7:0]                  pix_c;

   logic                        s1_valid;
   logic [8:0][16:0]            s1_prod;
   logic [3:0]                  s1_sh;
   logic [7:0]                  s1_off;
   logic [HC_W-1:0]             s1_hc;
   logic [VC_W-1:0]             s1_vc;

   logic                        s2_valid;
   logic signed [20:0]          s2_sum;
   logic [3:0]                  s2_sh;
   logic [7:0]                  s2_off;
   logic [HC_W-1:0]             s2_hc;
   logic [VC_W-1:0]             s2_vc;

   assign advance          = bus.out_ready_in | ~bus.data_valid_out;
   assign bus.in_ready_out = advance;

   // Kernel registers load on the pulse regardless of stalls; stage 1 samples them.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         k_coeffs <= '0;
         k_shift  <= '0;
         k_offset <= '0;
      end else if (bus.kernel_load_in) begin
         k_coeffs <= bus.coeffs_in;
         k_shift  <= bus.shift_in;
         k_offset <= bus.offset_in;
      end
   end

   always_comb begin
      if (k_shift[7])
         k_sh = '0;
      else if (k_shift > 8'sd15)
         k_sh = 4'd15;
      else
         k_sh = k_shift[3:0];
   end

   for (genvar i = 0; i < 9; i++) begin : g_mul
      logic signed [16:0] coef_x;
      logic signed [16:0] pix_x;
      assign coef_x    = {{9{k_coeffs[i/3][i%3][7]}}, k_coeffs[i/3][i%3]};
      assign pix_x     = {9'b0, bus.window_in[i/3][i%3]};
      assign prod_c[i] = coef_x * pix_x;
   end

   function automatic logic signed [20:0] sx(input logic [16:0] p);
      return {{4{p[16]}}, p};
   endfunction

   always_comb begin
      sum_c = sx(s1_prod[0]) + sx(s1_prod[1]) + sx(s1_prod[2])
            + sx(s1_prod[3]) + sx(s1_prod[4]) + sx(s1_prod[5])
            + sx(s1_prod[6]) + sx(s1_prod[7]) + sx(s1_prod[8]);
   end

   always_comb begin
      shifted_c = s2_sum >>> s2_sh;
`ifdef CONV_ABS_EN
      mag_c = shifted_c[20] ? -shifted_c : shifted_c;
`else
      mag_c = shifted_c;
`endif
      res_c = mag_c + {{13{s2_off[7]}}, s2_off};
      if (res_c[20])
         pix_c = '0;
      else if (res_c > 21'sd255)
         pix_c = '1;
      else
         pix_c = res_c[7:0];
   end

   // Data registers only load with valid entries so outputs stay stable across bubbles.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid           <= 1'b0;
         s1_prod            <= '0;
         s1_sh              <= '0;
         s1_off             <= '0;
         s1_hc              <= '0;
         s1_vc              <= '0;
         s2_valid           <= 1'b0;
         s2_sum             <= '0;
         s2_sh              <= '0;
         s2_off             <= '0;
         s2_hc              <= '0;
         s2_vc              <= '0;
         bus.data_valid_out <= 1'b0;
         bus.pixel_out      <= '0;
         bus.hcount_out     <= '0;
         bus.vcount_out     <= '0;
      end else if (advance) begin
         s1_valid           <= bus.data_valid_in;
         s2_valid           <= s1_valid;
         bus.data_valid_out <= s2_valid;
         if (bus.data_valid_in) begin
            s1_prod <= prod_c;
            s1_sh   <= k_sh;
            s1_off  <= k_offset;
            s1_hc   <= bus.hcount_in;
            s1_vc   <= bus.vcount_in;
         end
         if (s1_valid) begin
            s2_sum <= sum_c;
            s2_sh  <= s1_sh;
            s2_off <= s1_off;
            s2_hc  <= s1_hc;
            s2_vc  <= s1_vc;
         end
         if (s2_valid) begin
            bus.pixel_out  <= pix_c;
            bus.hcount_out <= s2_hc;
            bus.vcount_out <= s2_vc;
         end
      end
   end
endmodule

// File: tb/tb_convolution_3x3.sv
// Randomized and directed bench for convolution_3x3 with a scoreboard of expected pixels.
module tb_convolution_3x3;
   localparam int HC_W = 11;
   localparam int VC_W = 10;

   typedef logic [71:0] mat_t;
   typedef struct { int pix; int hc; int vc; } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   convolution_3x3_if #(.HC_W(HC_W), .VC_W(VC_W)) bus ();

   convolution_3x3 #(.HC_W(HC_W), .VC_W(VC_W)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus.slave)
   );

   int   n_checks = 0;
   int   n_pass = 0;
   int   n_out = 0;
   int   stall_cycles = 0;
   int   last_pix = -1;
   exp_t sb[$];
   mat_t m_coeffs = '0;
   int   m_shift = 0;
   int   m_off = 0;
   bit   done = 0;

   task automatic check(input string tag, input int got, input int expv);
      n_checks++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
   endtask

   // Reference: plain integer convolution, floor division by 2^sh, offset, clamp.
   function automatic int model_pixel(input mat_t win, input mat_t k, input int shift, input int off);
      int sum = 0;
      int sh, d, q, r;
      for (int i = 0; i < 9; i++) begin
         logic signed [7:0] cv;
         logic [7:0]        pv;
         cv = k[8*i +: 8];
         pv = win[8*i +: 8];
         sum += int'(cv) * int'(pv);
      end
      sh = (shift < 0) ? 0 : ((shift > 15) ? 15 : shift);
      d  = 1 << sh;
      if (sum >= 0) q = sum / d;
      else          q = -((-sum + d - 1) / d);
`ifdef CONV_ABS_EN
      if (q < 0) q = -q;
`endif
      r = q + off;
      if (r < 0) r = 0;
      else if (r > 255) r = 255;
      return r;
   endfunction

   // Element order [0][0],[0][1],...,[2][2]; column index 0 is the left column.
   function automatic mat_t mk(input int a, input int b, input int c, input int d, input int e,
                               input int f, input int g, input int h, input int i);
      return {i[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   function automatic mat_t cols(input int l, input int m, input int r);
      return mk(l, m, r, l, m, r, l, m, r);
   endfunction

   function automatic mat_t rows(input int t, input int m, input int b);
      return mk(t, t, t, m, m, m, b, b, b);
   endfunction

   function automatic mat_t rand_win();
      mat_t w;
      for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   function automatic mat_t rand_kernel();
      mat_t k;
      for (int i = 0; i < 9; i++) k[8*i +: 8] = 8'(int'($urandom_range(0, 8)) - 4);
      return k;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_coeffs = '0;
         m_shift  = 0;
         m_off    = 0;
      end else begin
         if (bus.data_valid_out) begin
            if (sb.size() == 0) begin
               check("queue_depth", int'(sb.size()), 1);
            end else if (!bus.out_ready_in) begin
               stall_cycles++;
               check("stall_in_ready", int'(bus.in_ready_out), 0);
               check("stall_pix", int'(bus.pixel_out), sb[0].pix);
               check("stall_hc", int'(bus.hcount_out), sb[0].hc);
            end else begin
               check("pix", int'(bus.pixel_out), sb[0].pix);
               check("hc", int'(bus.hcount_out), sb[0].hc);
               check("vc", int'(bus.vcount_out), sb[0].vc);
               last_pix = int'(bus.pixel_out);
               n_out++;
               void'(sb.pop_front());
            end
         end
         if (bus.data_valid_in && bus.in_ready_out) begin
            exp_t e;
            e.pix = model_pixel(bus.window_in, m_coeffs, m_shift, m_off);
            e.hc  = int'(bus.hcount_in);
            e.vc  = int'(bus.vcount_in);
            sb.push_back(e);
         end
         if (bus.kernel_load_in) begin
            m_coeffs = bus.coeffs_in;
            m_shift  = int'(bus.shift_in);
            m_off    = int'(bus.offset_in);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_kernel(input mat_t k, input int sh, input int off);
      bus.coeffs_in      = k;
      bus.shift_in       = sh[7:0];
      bus.offset_in      = off[7:0];
      bus.kernel_load_in = 1'b1;
   endtask

   task automatic load_kernel(input mat_t k, input int sh, input int off);
      set_kernel(k, sh, off);
      tick();
      bus.kernel_load_in = 1'b0;
   endtask

   task automatic send_win(input mat_t w, input int hc, input int vc);
      bit acc = 0;
      bus.window_in     = w;
      bus.hcount_in     = hc[HC_W-1:0];
      bus.vcount_in     = vc[VC_W-1:0];
      bus.data_valid_in = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready_out;
         @(posedge clk);
         #1;
         bus.kernel_load_in = 1'b0;
      end
      bus.data_valid_in = 1'b0;
      if (!acc) check("accept_timeout", int'(acc), 1);
   endtask

   task automatic drain();
      bus.out_ready_in = 1'b1;
      for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
      check("drain", int'(sb.size()), 0);
      tick();
   endtask

   task automatic one(input string tag, input mat_t w, input int expv);
      send_win(w, 1, 1);
      drain();
      check(tag, last_pix, expv);
   endtask

   initial begin
      int cnt;
      int out0;

      bus.kernel_load_in = 1'b0;
      bus.coeffs_in      = '0;
      bus.shift_in       = '0;
      bus.offset_in      = '0;
      bus.data_valid_in  = 1'b0;
      bus.window_in      = '0;
      bus.hcount_in      = '0;
      bus.vcount_in      = '0;
      bus.out_ready_in   = 1'b1;
      tick();
      tick();
      check("rst_valid", int'(bus.data_valid_out), 0);
      check("rst_pix", int'(bus.pixel_out), 0);
      check("rst_hc", int'(bus.hcount_out), 0);
      check("rst_vc", int'(bus.vcount_out), 0);
      check("rst_in_ready", int'(bus.in_ready_out), 1);
      rst_n = 1'b1;
      tick();

      // Identity kernel and latency from the accepting cycle
      load_kernel(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0);
      tick();
      send_win(mk(0, 0, 0, 0, 100, 0, 0, 0, 0), 11, 22);
      cnt = 1;
      while (!bus.data_valid_out && cnt < 10) begin
         tick();
         cnt++;
      end
      check("latency", cnt, 3);
      drain();
      check("identity", last_pix, 100);

      load_kernel(mk(1, 2, 1, 2, 4, 2, 1, 2, 1), 4, 0);
      one("gauss200", rows(200, 200, 200), 200);
      one("gauss255", rows(255, 255, 255), 255);

      load_kernel(mk(0, -1, 0, -1, 5, -1, 0, -1, 0), 0, 16);
      one("sharpen_hi", mk(0, 0, 0, 0, 255, 0, 0, 0, 0), 255);
`ifdef CONV_ABS_EN
      one("sharpen_lo", mk(255, 255, 255, 255, 0, 255, 255, 255, 255), 255);
`else
      one("sharpen_lo", mk(255, 255, 255, 255, 0, 255, 255, 255, 255), 0);
`endif

      load_kernel(mk(1, 0, -1, 2, 0, -2, 1, 0, -1), 0, 0);
`ifdef CONV_ABS_EN
      one("sobel_x", cols(10, 30, 50), 160);
`else
      one("sobel_x", cols(10, 30, 50), 0);
`endif
      // Sobel Y loaded in the same cycle as this accept: it must still see Sobel X
      set_kernel(mk(1, 2, 1, 0, 0, 0, -1, -2, -1), 0, 0);
      one("load_same_cycle_old", cols(50, 30, 10), 160);
      one("load_next_new", rows(50, 30, 10), 160);

      // Stream of 8 with a 5-cycle downstream stall
      load_kernel(mk(1, 2, 1, 2, 4, 2, 1, 2, 1), 4, -3);
      out0 = n_out;
      stall_cycles = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send_win(rand_win(), 200 + i, 5 + i);
         end
         begin
            repeat (4) tick();
            bus.out_ready_in = 1'b0;
            repeat (5) tick();
            bus.out_ready_in = 1'b1;
         end
      join
      drain();
      check("stream_count", n_out - out0, 8);
      check("stall_cycles", stall_cycles, 5);

      // Reset with windows in flight
      bus.out_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) send_win(rand_win(), 300 + i, 9);
      check("pre_rst_valid", int'(bus.data_valid_out), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(bus.data_valid_out), 0);
      check("mid_rst_pix", int'(bus.pixel_out), 0);
      tick();
      check("mid_rst_in_ready", int'(bus.in_ready_out), 1);
      rst_n = 1'b1;
      bus.out_ready_in = 1'b1;
      tick();
      one("post_rst_zero_kernel", rand_win(), 0);

      // Random kernels, gaps and backpressure
      load_kernel(rand_kernel(), int'($urandom_range(0, 4)), int'($urandom_range(0, 100)));
      out0 = n_out;
      done = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 7) == 0)
                  set_kernel(rand_kernel(), int'($urandom_range(0, 20)) - 2,
                             int'($urandom_range(0, 255)) - 128);
               send_win(rand_win(), i, int'($urandom_range(0, 1023)));
               repeat ($urandom_range(0, 2)) tick();
            end
            done = 1;
         end
         begin
            while (!done) begin
               tick();
               bus.out_ready_in = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();
      check("random_count", n_out - out0, 60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got %0d checks, expected run to finish", n_checks);
      $fatal(1, "timeout");
   end
endmodule
